bus_responder: RTL and testbench
================================

# bus_responder

Memory-side responder for the 6502 core's system bus. It answers CPU read and write cycles with a fixed number of wait states. It decodes each address into RAM, ROM, a small I/O register file or unmapped space. It also provides a host preload port for ROM and an 8-bit interval timer with an interrupt line, and sits between `cpu_core` and the board pins.

## Interface
Parameters:
- `RAM_DEPTH`, 2048: RAM bytes, mapped at 0x0000–(RAM_DEPTH-1); power of two, max 32768.
- `ROM_DEPTH`, 4096: ROM bytes, mapped at 0xF000–0xFFFF; fixed at 4096.
- `WAIT_STATES`, 0: extra cycles inserted before each response; range 0–15.

Ports:
- `clk` in 1: clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `req` in 1: access request, level; initiator holds it until `ready`.
- `rw` in 1: 1 = read, 0 = write; sampled with `req`.
- `addr` in 16: byte address.
- `wdata` in 8: write data.
- `rdata` out 8: read data, valid while `ready`=1.
- `ready` out 1: one-cycle completion pulse.
- `bus_err` out 1: pulses with `ready` on an unmapped access or a ROM write.
- `load_en` in 1: preload mode; blocks CPU accesses.
- `load_we` in 1: ROM write strobe while `load_en`=1.
- `load_addr` in 12: ROM offset.
- `load_data` in 8: ROM byte.
- `led` out 8: LED register.
- `irq` out 1: timer interrupt, level.

## Operation
- FSM states are IDLE, WAIT and RESP.
- **IDLE:**
  - If `load_en`=0 and `req`=1, latch `addr`, `rw` and `wdata` and load the wait counter with WAIT_STATES.
  - Go to RESP if WAIT_STATES=0, else to WAIT.
- **WAIT:** decrement the counter each cycle; go to RESP in the cycle the counter reaches 1.
- **RESP:**
  - Perform the access on the latched values.
  - Register `rdata` and `bus_err`, drive `ready`=1 for that one cycle, then go unconditionally to IDLE.
- **Address decode:**
  - 0x0000–RAM_DEPTH-1: RAM, read and write.
  - 0x8000: LED register, read and write.
  - 0x8001: timer reload value, read and write.
  - 0x8002: status. Read returns {7'b0, expired flag}. A write of any data clears the flag.
  - 0x8003: control. Bit 0 is the timer enable; read returns {7'b0, en}.
  - 0xF000–0xFFFF: ROM, read-only. A write is ignored and sets `bus_err`; a read returns the byte.
  - Any other address: a read returns 0xFF, a write is ignored, and `bus_err`=1.
- **`rdata` on writes:** `rdata` holds its previous value.
- **Preload:**
  - While `load_en`=1 the FSM stays in IDLE and `req` is ignored.
  - Each cycle with `load_we`=1 writes `load_data` to ROM[`load_addr`].
  - If `load_en` rises while the FSM is in WAIT or RESP, the in-flight access completes first.
- **Timer:**
  - The counter is 8 bits.
  - When enabled: if count is 0, load reload and set the flag; otherwise decrement by 1.
  - Period is reload+1 cycles; reload 0 sets the flag every cycle.
  - `irq` = flag.
  - A write to reload takes effect at the next reload.
  - When disabled, count holds its value.
- **Simultaneous events:** if a status-clear write and a timer expiry occur in the same cycle, expiry wins and the flag stays 1.

## Timing
- **Reset values:** `rdata`=0x00, `ready`=0, `bus_err`=0, `led`=0x00, `irq`=0; reload, control, count and flag all 0; FSM in IDLE.
- **Reset and memory contents:**
  - RAM and ROM arrays are not reset.
  - Reset mid-access aborts the access, and no `ready` is issued.
  - A write in flight when reset arrives has no effect.
- **Latency:**
  - `req` sampled at edge N gives `ready`=1 during cycle N+1+WAIT_STATES.
  - Register and RAM writes commit at the end of the RESP cycle.
- **Throughput:** one access per WAIT_STATES+2 cycles. A `req` still high during RESP is re-sampled in the following IDLE cycle as a new access.
- **Synchronous memories:** RAM and ROM reads are synchronous. The array is read in the cycle before RESP, and the value is registered so it is valid during RESP.
- **Preload:** ROM writes take one cycle and are readable on the next CPU access.

## Test plan
- **Reset:** assert `reset` mid-WAIT with WAIT_STATES=3 -> all outputs at reset values; no `ready` pulse until a new `req`.
- **RAM:**
  - Write 0x5A to 0x0010, then read 0x0010 -> `rdata`=0x5A, `bus_err`=0.
  - Read 0x07FF after writing 0xC3 to it -> 0xC3.
- **Preload:** preload 0xA9 at offset 0x000 and 0x42 at 0xFFF, drop `load_en`, read 0xF000 and 0xFFFF -> 0xA9 and 0x42. Write 0x00 to 0xF000 -> `bus_err`=1, and a re-read still returns 0xA9.
- **Wait states:** with WAIT_STATES=2, `req` sampled at edge 0 -> `ready` high in cycle 3 only. With `req` held high, the next `ready` comes in cycle 7.
- **Unmapped access:** read 0x4000 -> `rdata`=0xFF, `bus_err`=1 with `ready`. Write 0x77 to 0x8000 -> `led`=0x77.
- **Timer:**
  - Write 3 to 0x8001 and 1 to 0x8003 -> `irq` rises every 4 cycles and stays high.
  - A write to 0x8002 clears `irq` unless it coincides with an expiry.
  - A read of 0x8002 while set -> 0x01.

Source files
------------

// File: rtl/bus_responder.sv
// Memory-side responder for the 6502 system bus: RAM, ROM with host preload,
// a small I/O register file and an 8-bit interval timer, with fixed wait states.
module bus_responder #(
    parameter int unsigned RAM_DEPTH   = 2048,
    parameter int unsigned ROM_DEPTH   = 4096,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        rw,
    input  logic [15:0] addr,
    input  logic [7:0]  wdata,
    output logic [7:0]  rdata,
    output logic        ready,
    output logic        bus_err,
    input  logic        load_en,
    input  logic        load_we,
    input  logic [11:0] load_addr,
    input  logic [7:0]  load_data,
    output logic [7:0]  led,
    output logic        irq
);

    localparam int unsigned RAM_AW   = $clog2(RAM_DEPTH);
    localparam logic [15:0] RamLimit = 16'(RAM_DEPTH - 1);
    localparam logic [3:0]  WaitInit = 4'(WAIT_STATES);
    localparam bit          NoWait   = (WAIT_STATES == 0);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StWait = 2'd1;
    localparam logic [1:0] StResp = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [3:0]  wcnt_q, wcnt_d;
    logic [15:0] addr_q;
    logic        rw_q;
    logic [7:0]  wdata_q;

    logic [7:0]  rdata_q;
    logic        ready_q;
    logic        bus_err_q;

    logic [7:0]  led_q, reload_q, count_q;
    logic        en_q, flag_q;

    logic [7:0]  ram [RAM_DEPTH];
    logic [7:0]  rom [ROM_DEPTH];

    logic        accept, enter_resp, wr_commit, wr_stat, expire;
    logic [15:0] acc_addr;
    logic        acc_rw;
    logic        is_ram, is_reg, is_rom;
    logic [7:0]  rd_val;
    logic        err_val;

    assign accept     = (state_q == StIdle) && !load_en && req;
    assign enter_resp = (state_d == StResp) && (state_q != StResp);
    assign wr_commit  = (state_q == StResp) && !rw_q;

    // In IDLE the access is being accepted this edge, so decode the live bus.
    assign acc_addr = (state_q == StIdle) ? addr : addr_q;
    assign acc_rw   = (state_q == StIdle) ? rw : rw_q;

    assign is_ram = acc_addr <= RamLimit;
    assign is_reg = acc_addr[15:2] == 14'h2000;
    assign is_rom = acc_addr[15:12] == 4'hF;

    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        case (state_q)
            StIdle: begin
                if (accept) begin
                    wcnt_d  = WaitInit;
                    state_d = NoWait ? StResp : StWait;
                end
            end
            StWait: begin
                if (wcnt_q == 4'd1) state_d = StResp;
                else                wcnt_d  = wcnt_q - 4'd1;
            end
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        rd_val  = 8'hFF;
        err_val = 1'b1;
        if (is_ram) begin
            rd_val  = ram[acc_addr[RAM_AW-1:0]];
            err_val = 1'b0;
        end else if (is_reg) begin
            err_val = 1'b0;
            case (acc_addr[1:0])
                2'd0:    rd_val = led_q;
                2'd1:    rd_val = reload_q;
                2'd2:    rd_val = {7'b0, flag_q};
                default: rd_val = {7'b0, en_q};
            endcase
        end else if (is_rom) begin
            rd_val  = rom[acc_addr[11:0]];
            err_val = !acc_rw;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            wcnt_q    <= 4'd0;
            addr_q    <= 16'd0;
            rw_q      <= 1'b1;
            wdata_q   <= 8'd0;
            rdata_q   <= 8'd0;
            ready_q   <= 1'b0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wcnt_q    <= wcnt_d;
            ready_q   <= enter_resp;
            bus_err_q <= enter_resp && err_val;
            if (accept) begin
                addr_q  <= addr;
                rw_q    <= rw;
                wdata_q <= wdata;
            end
            if (enter_resp && acc_rw) rdata_q <= rd_val;
        end
    end

    assign wr_stat = wr_commit && is_reg && (addr_q[1:0] == 2'd2);
    assign expire  = en_q && (count_q == 8'd0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            led_q    <= 8'd0;
            reload_q <= 8'd0;
            en_q     <= 1'b0;
            count_q  <= 8'd0;
            flag_q   <= 1'b0;
        end else begin
            if (wr_commit && is_reg) begin
                case (addr_q[1:0])
                    2'd0:    led_q    <= wdata_q;
                    2'd1:    reload_q <= wdata_q;
                    2'd3:    en_q     <= wdata_q[0];
                    default: ;
                endcase
            end
            if (en_q) begin
                if (count_q == 8'd0) count_q <= reload_q;
                else                 count_q <= count_q - 8'd1;
            end
            // Expiry beats a coincident status clear.
            if (expire)       flag_q <= 1'b1;
            else if (wr_stat) flag_q <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_commit && is_ram) ram[addr_q[RAM_AW-1:0]] <= wdata_q;
    end

    always_ff @(posedge clk) begin
        if (load_en && load_we) rom[load_addr] <= load_data;
    end

    assign rdata   = rdata_q;
    assign ready   = ready_q;
    assign bus_err = bus_err_q;
    assign led     = led_q;
    assign irq     = flag_q;

endmodule

// File: tb/tb_bus_responder.sv
// Directed bench for bus_responder: one instance with two wait states for the
// main checks and one with three wait states, fed the same bus, for reset abort.
module tb_bus_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        req, rw;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic        load_en, load_we;
    logic [11:0] load_addr;
    logic [7:0]  load_data;

    logic [7:0]  rdata2, led2, rdata3, led3;
    logic        ready2, berr2, irq2, ready3, berr3, irq3;

    int total  = 0;
    int passed = 0;

    always #5 clk = ~clk;

    bus_responder #(.RAM_DEPTH(2048), .ROM_DEPTH(4096), .WAIT_STATES(2)) dut (
        .clk(clk), .reset(reset), .req(req), .rw(rw), .addr(addr), .wdata(wdata),
        .rdata(rdata2), .ready(ready2), .bus_err(berr2),
        .load_en(load_en), .load_we(load_we), .load_addr(load_addr), .load_data(load_data),
        .led(led2), .irq(irq2)
    );

    bus_responder #(.RAM_DEPTH(2048), .ROM_DEPTH(4096), .WAIT_STATES(3)) dut3 (
        .clk(clk), .reset(reset), .req(req), .rw(rw), .addr(addr), .wdata(wdata),
        .rdata(rdata3), .ready(ready3), .bus_err(berr3),
        .load_en(load_en), .load_we(load_we), .load_addr(load_addr), .load_data(load_data),
        .led(led3), .irq(irq3)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One CPU access on the two-wait-state instance; leaves both instances idle.
    task automatic access(input logic r, input logic [15:0] a, input logic [7:0] d,
                          output logic [7:0] rd, output logic e);
        bit seen;
        seen = 1'b0;
        rd   = 8'h00;
        e    = 1'b0;
        req  = 1'b1;
        rw   = r;
        addr = a;
        wdata = d;
        for (int i = 0; i < 20 && !seen; i++) begin
            tick();
            if (ready2) begin
                seen = 1'b1;
                rd   = rdata2;
                e    = berr2;
            end
        end
        req = 1'b0;
        check("ready_seen", {7'b0, seen}, 8'h01);
        tick();
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [7:0] rd;
        logic       e;
        logic [7:0] pattern;
        int         nready;

        reset = 1'b1;
        req = 1'b0; rw = 1'b1; addr = 16'h0000; wdata = 8'h00;
        load_en = 1'b0; load_we = 1'b0; load_addr = 12'h000; load_data = 8'h00;
        tick();
        tick();
        reset = 1'b0;
        #1;
        check("rst_rdata", rdata2, 8'h00);
        check("rst_ready", {7'b0, ready2}, 8'h00);
        check("rst_bus_err", {7'b0, berr2}, 8'h00);
        check("rst_led", led2, 8'h00);
        check("rst_irq", {7'b0, irq2}, 8'h00);

        // Reset lands while the three-wait-state instance is in WAIT.
        req = 1'b1; rw = 1'b1; addr = 16'h0010;
        tick();
        tick();
        reset = 1'b1;
        req   = 1'b0;
        #1;
        check("midwait_rdata", rdata3, 8'h00);
        check("midwait_ready", {7'b0, ready3}, 8'h00);
        check("midwait_bus_err", {7'b0, berr3}, 8'h00);
        check("midwait_led", led3, 8'h00);
        check("midwait_irq", {7'b0, irq3}, 8'h00);
        tick();
        tick();
        reset  = 1'b0;
        nready = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (ready2 || ready3) nready++;
        end
        check("no_ready_after_reset", 8'(nready), 8'h00);

        access(1'b0, 16'h0010, 8'h5A, rd, e);
        check("ram_wr_err", {7'b0, e}, 8'h00);
        access(1'b1, 16'h0010, 8'h00, rd, e);
        check("ram_rd_0010", rd, 8'h5A);
        check("ram_rd_err", {7'b0, e}, 8'h00);
        access(1'b0, 16'h07FF, 8'hC3, rd, e);
        check("wr_holds_rdata", rd, 8'h5A);
        access(1'b1, 16'h07FF, 8'h00, rd, e);
        check("ram_rd_07ff", rd, 8'hC3);

        // Preload with a pending CPU request that must be ignored.
        load_en = 1'b1; load_we = 1'b1;
        req = 1'b1; rw = 1'b1; addr = 16'h4000;
        load_addr = 12'h000; load_data = 8'hA9;
        nready = 0;
        tick();
        if (ready2 || ready3) nready++;
        load_addr = 12'hFFF; load_data = 8'h42;
        tick();
        if (ready2 || ready3) nready++;
        load_we = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (ready2 || ready3) nready++;
        end
        req = 1'b0;
        load_en = 1'b0;
        tick();
        check("no_ready_in_preload", 8'(nready), 8'h00);

        access(1'b1, 16'hF000, 8'h00, rd, e);
        check("rom_rd_f000", rd, 8'hA9);
        check("rom_rd_err", {7'b0, e}, 8'h00);
        access(1'b1, 16'hFFFF, 8'h00, rd, e);
        check("rom_rd_ffff", rd, 8'h42);
        access(1'b0, 16'hF000, 8'h00, rd, e);
        check("rom_wr_err", {7'b0, e}, 8'h01);
        check("rom_wr_rdata_hold", rd, 8'h42);
        access(1'b1, 16'hF000, 8'h00, rd, e);
        check("rom_reread", rd, 8'hA9);

        // req held: bit k of pattern is ready during cycle k+1 after sampling edge 0.
        req = 1'b1; rw = 1'b1; addr = 16'h0010;
        pattern = 8'h00;
        for (int k = 0; k < 8; k++) begin
            tick();
            pattern[k] = ready2;
        end
        req = 1'b0;
        tick();
        tick();
        tick();
        check("wait_state_pattern", pattern, 8'h44);

        access(1'b1, 16'h4000, 8'h00, rd, e);
        check("unmapped_rdata", rd, 8'hFF);
        check("unmapped_err", {7'b0, e}, 8'h01);
        access(1'b0, 16'h8000, 8'h77, rd, e);
        check("led_value", led2, 8'h77);
        access(1'b1, 16'h8000, 8'h00, rd, e);
        check("led_readback", rd, 8'h77);

        access(1'b0, 16'h8001, 8'h03, rd, e);
        check("irq_before_enable", {7'b0, irq2}, 8'h00);
        access(1'b0, 16'h8003, 8'h01, rd, e);
        check("irq_after_enable", {7'b0, irq2}, 8'h01);
        // This clear commits on an expiry edge, so the flag must survive.
        access(1'b0, 16'h8002, 8'h00, rd, e);
        check("clear_vs_expiry", {7'b0, irq2}, 8'h01);
        access(1'b0, 16'h8002, 8'h00, rd, e);
        check("irq_cleared", {7'b0, irq2}, 8'h00);
        tick();
        check("irq_still_low", {7'b0, irq2}, 8'h00);
        tick();
        check("irq_reexpire", {7'b0, irq2}, 8'h01);
        access(1'b1, 16'h8002, 8'h00, rd, e);
        check("status_read", rd, 8'h01);
        access(1'b1, 16'h8003, 8'h00, rd, e);
        check("ctrl_read", rd, 8'h01);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
